// File: rtl/matrix_fb_arbiter.sv
// matrix_fb_arbiter: shares one single-port, double-buffered frame-buffer RAM
// between the matrix scan reader (priority) and the UART pixel writer.
// A starvation counter lets a waiting writer override the scanner, and the
// front/back banks swap only on a scan frame boundary.
// Optional feature macro: MATRIX_FB_WMASK_EN adds a per-colour write mask input
// (wr_mask) that drives mem_be on writes; without it mem_be stays 3'b111.
module matrix_fb_arbiter #(
    parameter int addr_bits    = 6,
    parameter int data_bits    = 24,
    parameter int starve_limit = 4
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 scan_req,
    input  logic [addr_bits-1:0] scan_addr,
    output logic                 scan_ready,
    output logic                 scan_valid,
    output logic [data_bits-1:0] scan_data,
    input  logic                 frame_start,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [addr_bits-1:0] wr_addr,
    input  logic [data_bits-1:0] wr_data,
`ifdef MATRIX_FB_WMASK_EN
    input  logic [2:0]           wr_mask,
`endif
    input  logic                 swap_req,
    output logic                 swap_done,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [addr_bits:0]   mem_addr,
    output logic [data_bits-1:0] mem_wdata,
    output logic [2:0]           mem_be,
    input  logic [data_bits-1:0] mem_rdata
);

    localparam int cnt_w = $clog2(starve_limit + 1);
    localparam logic [cnt_w-1:0] starve_max = cnt_w'(starve_limit);

    logic [cnt_w-1:0]     starve_cnt_q, starve_cnt_d;
    logic                 front_q, front_d;
    logic                 swap_pending_q, swap_pending_d;
    logic                 swap_done_q, swap_done_d;
    logic                 scan_valid_q, scan_valid_d;
    logic                 mem_en_q, mem_en_d;
    logic                 mem_we_q, mem_we_d;
    logic [addr_bits:0]   mem_addr_q, mem_addr_d;
    logic [data_bits-1:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]           mem_be_q, mem_be_d;

    logic ovr;
    logic rd_acc;
    logic wr_acc;
    logic swap_now;
    logic front_next;

    // Handshake: scanner has priority unless the writer has been starved long enough.
    assign ovr        = wr_valid & (starve_cnt_q == starve_max);
    assign wr_ready   = ~scan_req | ovr;
    assign scan_ready = ~ovr;
    assign rd_acc     = scan_req & scan_ready;
    assign wr_acc     = wr_valid & wr_ready;

    // A swap takes effect in the frame_start cycle itself, so accesses accepted
    // in that cycle already target the new banks.
    assign swap_now   = frame_start & (swap_pending_q | swap_req);
    assign front_next = front_q ^ swap_now;

    assign scan_data  = mem_rdata;
    assign scan_valid = scan_valid_q;
    assign swap_done  = swap_done_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;

    // Next-state: bank bookkeeping, starvation counter and the RAM command register.
    always_comb begin
        front_d        = front_next;
        swap_pending_d = swap_pending_q;
        swap_done_d    = swap_now;
        starve_cnt_d   = starve_cnt_q;
        mem_en_d       = rd_acc | wr_acc;
        mem_we_d       = wr_acc;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_be_d       = mem_be_q;
        // Read data returns one cycle after the RAM read strobe.
        scan_valid_d   = mem_en_q & ~mem_we_q;

        if (swap_now) begin
            swap_pending_d = 1'b0;
        end else if (swap_req) begin
            swap_pending_d = 1'b1;
        end

        if (!wr_valid || wr_acc) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != starve_max) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        // Reads and writes are mutually exclusive by construction of the handshake.
        if (wr_acc) begin
            mem_addr_d  = {~front_next, wr_addr};
            mem_wdata_d = wr_data;
`ifdef MATRIX_FB_WMASK_EN
            mem_be_d    = wr_mask;
`else
            mem_be_d    = 3'b111;
`endif
        end else if (rd_acc) begin
            mem_addr_d  = {front_next, scan_addr};
            mem_be_d    = 3'b111;
        end
    end

    // State and RAM command registers; everything returns to idle on reset.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            starve_cnt_q   <= '0;
            front_q        <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b0;
            scan_valid_q   <= 1'b0;
            mem_en_q       <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_be_q       <= 3'b111;
        end else begin
            starve_cnt_q   <= starve_cnt_d;
            front_q        <= front_d;
            swap_pending_q <= swap_pending_d;
            swap_done_q    <= swap_done_d;
            scan_valid_q   <= scan_valid_d;
            mem_en_q       <= mem_en_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_be_q       <= mem_be_d;
        end
    end

endmodule

// File: tb/tb_matrix_fb_arbiter.sv
// Testbench for matrix_fb_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_matrix_fb_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        scan_req;
    logic [5:0]  scan_addr;
    logic        scan_ready;
    logic        scan_valid;
    logic [23:0] scan_data;
    logic        frame_start;
    logic        wr_valid;
    logic        wr_ready;
    logic [5:0]  wr_addr;
    logic [23:0] wr_data;
    logic [2:0]  wr_mask;
    logic        swap_req;
    logic        swap_done;
    logic        mem_en;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [23:0] mem_wdata;
    logic [2:0]  mem_be;
    logic [23:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [23:0] ref_mem [0:127];
    bit          m_front, m_pend;
    int          m_starve;
    bit          e_en, e_we, e_sd, p_rd;
    logic [6:0]  e_addr;
    logic [23:0] e_wdata, p_dat;
    logic [2:0]  e_be;

    // Fake RAM device
    logic [23:0] ram [0:127];
    logic        ram_loaded = 1'b0;

    always #5 clk = ~clk;

    matrix_fb_arbiter #(.addr_bits(6), .data_bits(24), .starve_limit(LIM)) dut (
        .clk(clk), .reset_b(reset_b),
        .scan_req(scan_req), .scan_addr(scan_addr), .scan_ready(scan_ready),
        .scan_valid(scan_valid), .scan_data(scan_data), .frame_start(frame_start),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef MATRIX_FB_WMASK_EN
        .wr_mask(wr_mask),
`endif
        .swap_req(swap_req), .swap_done(swap_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    function automatic logic [23:0] init_word(input int i);
        return (i * 24'h010203) ^ 24'h5A5A5A;
    endfunction

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 128; i++) ram[i] <= init_word(i);
            ram_loaded <= 1'b1;
            mem_rdata  <= '0;
        end else if (mem_en && !mem_we) begin
            mem_rdata <= ram[mem_addr];
        end else if (mem_en && mem_we) begin
            if (mem_be[2]) ram[mem_addr][23:16] <= mem_wdata[23:16];
            if (mem_be[1]) ram[mem_addr][15:8]  <= mem_wdata[15:8];
            if (mem_be[0]) ram[mem_addr][7:0]   <= mem_wdata[7:0];
        end
    end

    task automatic model_reset();
        m_front = 0; m_pend = 0; m_starve = 0;
        e_en = 0; e_we = 0; e_sd = 0; p_rd = 0;
        e_addr = '0; e_wdata = '0; e_be = 3'b111; p_dat = '0;
    endtask

    // One clock of traffic: drive, check handshake mid-cycle, advance the model,
    // then check the registered RAM command and read return after the edge.
    task automatic drive_cycle(input bit sreq, input logic [5:0] saddr,
                               input bit wv, input logic [5:0] waddr, input logic [23:0] wdat,
                               input bit fs, input bit swr, input logic [2:0] msk,
                               output bit racc, output bit wacc);
        bit ovr, swap, ewr, esr;
        logic [6:0]  a;
        logic [2:0]  eff;
        logic [23:0] rd_val;
        rd_val = '0;
        scan_req = sreq; scan_addr = saddr; wr_valid = wv; wr_addr = waddr;
        wr_data = wdat; frame_start = fs; swap_req = swr; wr_mask = msk;
        @(negedge clk);
        ovr = wv && (m_starve == LIM);
        ewr = !sreq || ovr;
        esr = !ovr;
        checks += 2;
        if (wr_ready !== ewr) begin failures++; $display("FAIL wr_ready: got %b want %b", wr_ready, ewr); end
        if (scan_ready !== esr) begin failures++; $display("FAIL scan_ready: got %b want %b", scan_ready, esr); end
        racc = sreq && esr;
        wacc = wv && ewr;
        swap = fs && (m_pend || swr);
        if (swap) m_front = !m_front;
        m_pend = swap ? 1'b0 : (swr ? 1'b1 : m_pend);
        if (!wv || wacc) m_starve = 0;
        else if (m_starve < LIM) m_starve++;
        e_en = racc || wacc;
        e_we = wacc;
        e_sd = swap;
`ifdef MATRIX_FB_WMASK_EN
        eff = msk;
`else
        eff = 3'b111;
`endif
        if (wacc) begin
            a = {~m_front, waddr};
            e_addr = a; e_wdata = wdat; e_be = eff;
            if (eff[2]) ref_mem[a][23:16] = wdat[23:16];
            if (eff[1]) ref_mem[a][15:8]  = wdat[15:8];
            if (eff[0]) ref_mem[a][7:0]   = wdat[7:0];
        end else if (racc) begin
            a = {m_front, saddr};
            e_addr = a; e_be = 3'b111;
            rd_val = ref_mem[a];
        end
        @(posedge clk); #1;
        checks += 4;
        if (mem_en !== e_en) begin failures++; $display("FAIL mem_en: got %b want %b", mem_en, e_en); end
        if (mem_we !== e_we) begin failures++; $display("FAIL mem_we: got %b want %b", mem_we, e_we); end
        if (swap_done !== e_sd) begin failures++; $display("FAIL swap_done: got %b want %b", swap_done, e_sd); end
        if (scan_valid !== p_rd) begin failures++; $display("FAIL scan_valid: got %b want %b", scan_valid, p_rd); end
        if (e_en) begin
            checks += 2;
            if (mem_addr !== e_addr) begin failures++; $display("FAIL mem_addr: got %0d want %0d", mem_addr, e_addr); end
            if (mem_be !== e_be) begin failures++; $display("FAIL mem_be: got %b want %b", mem_be, e_be); end
        end
        if (e_we) begin
            checks++;
            if (mem_wdata !== e_wdata) begin failures++; $display("FAIL mem_wdata: got %h want %h", mem_wdata, e_wdata); end
        end
        if (p_rd) begin
            checks++;
            if (scan_data !== p_dat) begin failures++; $display("FAIL scan_data: got %h want %h", scan_data, p_dat); end
        end
        p_rd = racc;
        p_dat = rd_val;
    endtask

    task automatic idle(input int n);
        bit r, w;
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 3'b111, r, w);
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        scan_req = 0; scan_addr = 0; wr_valid = 0; wr_addr = 0; wr_data = 0;
        frame_start = 0; swap_req = 0; wr_mask = 3'b111;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 8;
        if (mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
        if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        if (mem_addr !== 7'd0) begin failures++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
        if (mem_wdata !== 24'd0) begin failures++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        if (mem_be !== 3'b111) begin failures++; $display("FAIL reset_mem_be: got %b want 111", mem_be); end
        if (scan_valid !== 1'b0) begin failures++; $display("FAIL reset_scan_valid: got %b want 0", scan_valid); end
        if (swap_done !== 1'b0) begin failures++; $display("FAIL reset_swap_done: got %b want 0", swap_done); end
        if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
        @(posedge clk); #1;
        reset_b = 1'b1;
        idle(2);
    endtask

    task automatic test_scan_only();
        bit r, w;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1, 6'(i), 0, 0, 0, 0, 0, 3'b111, r, w);
            checks++;
            if (mem_addr !== 7'(i)) begin failures++; $display("FAIL scan_only_addr: got %0d want %0d", mem_addr, i); end
        end
        idle(3);
    endtask

    task automatic test_write_only();
        bit r, w;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(0, 0, 1, 6'(10 + i), 24'hAA0000 + 24'(i), 0, 0, 3'b111, r, w);
            checks += 3;
            if (w !== 1'b1) begin failures++; $display("FAIL write_only_accept: got %b want 1", w); end
            if (mem_addr !== 7'(74 + i)) begin failures++; $display("FAIL write_only_addr: got %0d want %0d", mem_addr, 74 + i); end
            if (mem_be !== 3'b111) begin failures++; $display("FAIL write_only_be: got %b want 111", mem_be); end
        end
        idle(2);
    endtask

    task automatic test_contention();
        bit r, w;
        logic [5:0] sa = 6'd20;
        logic [5:0] wa = 6'd30;
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1, sa, 1, wa, 24'h00BB00 + 24'(wa), 0, 0, 3'b111, r, w);
            checks++;
            if (w !== (i % 5 == 4)) begin failures++; $display("FAIL contention_win cyc%0d: got %b want %b", i, w, (i % 5 == 4)); end
            if (r) sa++;
            if (w) wa++;
        end
        idle(3);
    endtask

    task automatic test_swap();
        bit r, w;
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 3'b111, r, w);
        for (int i = 0; i < 8; i++) drive_cycle(1, 6'(i), 0, 0, 0, 0, 0, 3'b111, r, w);
        drive_cycle(1, 6'd9, 0, 0, 0, 1, 0, 3'b111, r, w);
        checks += 2;
        if (mem_addr[6] !== 1'b1) begin failures++; $display("FAIL swap_bank_fs: got %b want 1", mem_addr[6]); end
        if (swap_done !== 1'b1) begin failures++; $display("FAIL swap_done_pulse: got %b want 1", swap_done); end
        drive_cycle(0, 0, 1, 6'd3, 24'h123456, 0, 0, 3'b111, r, w);
        checks++;
        if (mem_addr !== 7'd3) begin failures++; $display("FAIL swap_write_bank: got %0d want 3", mem_addr); end
        idle(4);
        drive_cycle(1, 6'd3, 0, 0, 0, 1, 1, 3'b111, r, w);
        checks += 2;
        if (mem_addr !== 7'd3) begin failures++; $display("FAIL swap_back_addr: got %0d want 3", mem_addr); end
        if (swap_done !== 1'b1) begin failures++; $display("FAIL swap_back_done: got %b want 1", swap_done); end
        drive_cycle(1, 6'd4, 0, 0, 0, 1, 0, 3'b111, r, w);
        checks++;
        if (mem_addr !== 7'd4) begin failures++; $display("FAIL swap_no_pending: got %0d want 4", mem_addr); end
        idle(3);
    endtask

    task automatic test_reset_mid();
        bit r, w;
        drive_cycle(1, 6'd7, 0, 0, 0, 0, 0, 3'b111, r, w);
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 3'b111, r, w);
        checks++;
        if (scan_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_valid: got %b want 1", scan_valid); end
        reset_b = 1'b0;
        #1;
        checks += 3;
        if (scan_valid !== 1'b0) begin failures++; $display("FAIL midreset_scan_valid: got %b want 0", scan_valid); end
        if (mem_en !== 1'b0) begin failures++; $display("FAIL midreset_mem_en: got %b want 0", mem_en); end
        if (mem_be !== 3'b111) begin failures++; $display("FAIL midreset_mem_be: got %b want 111", mem_be); end
        scan_req = 0;
        @(posedge clk); #1;
        reset_b = 1'b1;
        model_reset();
        drive_cycle(1, 6'd5, 0, 0, 0, 1, 0, 3'b111, r, w);
        checks += 2;
        if (mem_addr !== 7'd5) begin failures++; $display("FAIL postreset_bank: got %0d want 5", mem_addr); end
        if (swap_done !== 1'b0) begin failures++; $display("FAIL postreset_swap: got %b want 0", swap_done); end
        idle(3);
    endtask

    task automatic test_wmask();
        bit r, w;
        drive_cycle(0, 0, 1, 6'd12, 24'hC0FFEE, 0, 0, 3'b010, r, w);
        checks++;
`ifdef MATRIX_FB_WMASK_EN
        if (mem_be !== 3'b010) begin failures++; $display("FAIL wmask_be: got %b want 010", mem_be); end
`else
        if (mem_be !== 3'b111) begin failures++; $display("FAIL wmask_be: got %b want 111", mem_be); end
`endif
        drive_cycle(1, 6'd12, 0, 0, 0, 0, 0, 3'b111, r, w);
        drive_cycle(0, 0, 1, 6'd13, 24'h777777, 0, 0, 3'b000, r, w);
        idle(3);
    endtask

    task automatic test_random();
        bit r, w;
        bit sreq = 0, wv = 0;
        logic [5:0] sa = 0, wa = 0;
        logic [23:0] wd = 0;
        logic [2:0] msk = 3'b111;
        w = 1; r = 1;
        for (int i = 0; i < 400; i++) begin
            if (r || !sreq) begin sreq = ($urandom_range(0, 3) != 0); sa = 6'($urandom); end
            if (w || !wv) begin
                wv = ($urandom_range(0, 2) != 0); wa = 6'($urandom);
                wd = 24'($urandom); msk = 3'($urandom);
            end
            drive_cycle(sreq, sa, wv, wa, wd, ($urandom_range(0, 7) == 0),
                        ($urandom_range(0, 9) == 0), msk, r, w);
        end
        idle(3);
        for (int i = 0; i < 128; i++) drive_cycle(1, 6'(i), 0, 0, 0, (i == 64), 0, 3'b111, r, w);
        idle(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_scan_only();
        test_write_only();
        test_contention();
        test_swap();
        test_reset_mid();
        test_wmask();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
